load_store_unit: RTL and testbench

- Produces the ReadData word consumed by the writeback result selection (ResultSrc=01) and drives data-memory stores.
- Sits between the ALU address output (ALUResult) and a handshaked data memory.
- Converts core load/store requests into word-aligned memory transactions with byte strobes, plus sign/zero extension on loads.
- Holds the core via Stall until the memory responds.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 33 +++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, FSM states and byte strobes.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Reserved encodings (011, 110, 111) fall through to a word access.
    function automatic lsu_size_t size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        // funct3[2] marks the unsigned variants (LBU/LHU).
        result = rdata;
        case (size_of(funct3))
            SZ_BYTE: result = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: result = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into handshaked word-aligned memory accesses.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring the low bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t state, state_next;
    logic [7:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        req;
    logic        misaligned;
    logic        timed_out;
    lsu_size_t   req_size;
    logic [3:0]  strb_c;
    logic [31:0] wdata_c;
    logic [31:0] load_word;

    assign req       = MemRead | MemWrite;
    assign req_size  = size_of(funct3);
    assign timed_out = (cnt == 8'(TIMEOUT - 1));
    assign Stall     = req && (state != DONE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_size == SZ_HALF) && Addr[0]) ||
                        ((req_size == SZ_WORD) && (Addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Replicate store data across the word, then shift it so the addressed lane carries it.
    always_comb begin
        strb_c  = STRB_WORD;
        wdata_c = WriteData;
        case (req_size)
            SZ_BYTE: begin
                strb_c  = STRB_BYTE << Addr[1:0];
                wdata_c = {4{WriteData[7:0]}} << {Addr[1:0], 3'b000};
            end
            SZ_HALF: begin
                strb_c  = STRB_HALF << {Addr[1], 1'b0};
                wdata_c = {2{WriteData[15:0]}} << {Addr[1], 4'b0000};
            end
            default: begin
                strb_c  = STRB_WORD;
                wdata_c = WriteData;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = misaligned ? DONE : ACCESS;
            ACCESS:  if (mem_ready || timed_out) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (load_word)
    );

    // A simultaneous read and write request is treated as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData  <= '0;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q  <= MemWrite;
                        f3_q  <= funct3;
                        off_q <= Addr[1:0];
                        cnt   <= '0;
                        if (misaligned) begin
                            bus_err <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {Addr[ADDR_W-1:2], 2'b00};
                            mem_wstrb <= strb_c;
                            mem_wdata <= wdata_c;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!we_q) ReadData <= load_word;
                    end else if (timed_out) begin
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        ReadData <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard testbench for load_store_unit: directed cases plus randomized loads/stores against a reference model.
// Honours LSU_MISALIGN_TRAP_EN so the expectations track the build of the design.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Addr, WriteData, ReadData;
    logic        Stall, bus_err;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    typedef struct {
        bit          err;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          req_cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rd   = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        logic [31:0] m = 32'h0;
        for (int i = 0; i < 4; i++)
            if (strb[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Take n bytes starting at byte offset off, then extend to 32 bits using plain arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input int off, input int n, input bit sgn);
        longint v;
        longint span;
        span = longint'(1) << (8 * n);
        v = (longint'(rd) >> (8 * off)) % span;
        if (sgn && n < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // delay = number of ACCESS cycles before mem_ready; negative means memory never answers.
    task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input int delay);
        exp_t e;
        int   n, off, k, stalls, exp_stall;
        bit   mis, done;
        n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = (n == 1) ? int'(a[1:0]) : (n == 2) ? 2 * int'(a[1]) : 0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        e.err   = 1'b0;
        e.we    = we;
        e.addr  = {a[31:2], 2'b00};
        e.strb  = 4'(((1 << n) - 1) << off);
        e.wdata = wd << (8 * off);
        if (mis) begin
            e.err = 1'b1; e.req_cycles = 0; e.rdata = exp_rd; exp_stall = 1;
        end else if (delay < 0) begin
            e.err = 1'b1; e.req_cycles = TO; exp_rd = 32'h0; e.rdata = 32'h0; exp_stall = 1 + TO;
        end else begin
            e.req_cycles = delay + 1;
            if (!we) exp_rd = model_load(rd, off, n, !f3[2]);
            e.rdata = exp_rd;
            exp_stall = 2 + delay;
        end
        sb.push_back(e);

        MemRead = !we; MemWrite = we; funct3 = f3; Addr = a; WriteData = wd; mem_rdata = rd;
        k = 0; stalls = 0; done = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (Stall) stalls++;
            else begin done = 1'b1; break; end
            @(posedge clk); #1;
            if (mem_req) begin
                mem_ready = (delay >= 0) && (k == delay);
                k++;
            end else begin
                mem_ready = 1'b0;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
        checkOutput("stall_released", done, 1'b1);
        if (done) checkOutput("stall_cycles", stalls, exp_stall);
        @(posedge clk); #1;
    endtask

    task automatic applyReset();
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; Addr = 32'h300; mem_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_pre_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_req", mem_req, 1'b0);
        checkOutput("rst_mid_readdata", ReadData, 32'h0);
        checkOutput("rst_mid_bus_err", bus_err, 1'b0);
        sb.delete();
        exp_rd = 32'h0;
        MemRead = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Monitor: pops expectations whenever the DUT completes a handshake or raises bus_err.
    initial begin
        int   req_cnt = 0;
        bit   pending = 1'b0;
        exp_t cur, e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_cnt = 0;
                pending = 1'b0;
            end else begin
                if (pending) begin
                    checkOutput("done_readdata", ReadData, cur.rdata);
                    checkOutput("done_bus_err", bus_err, 1'b0);
                    pending = 1'b0;
                end else if (bus_err) begin
                    checkOutput("err_expected", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        checkOutput("err_kind", e.err, 1'b1);
                        checkOutput("err_req_cycles", req_cnt, e.req_cycles);
                        checkOutput("err_readdata", ReadData, e.rdata);
                    end
                    req_cnt = 0;
                end
                if (mem_req) req_cnt++;
                if (mem_req && mem_ready) begin
                    checkOutput("resp_expected", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        cur = sb.pop_front();
                        checkOutput("acc_kind", cur.err, 1'b0);
                        checkOutput("mem_we", mem_we, cur.we);
                        checkOutput("mem_addr", mem_addr, cur.addr);
                        checkOutput("mem_wstrb", mem_wstrb, cur.strb);
                        if (cur.we)
                            checkOutput("mem_wdata", mem_wdata & lane_mask(cur.strb),
                                        cur.wdata & lane_mask(cur.strb));
                        checkOutput("req_cycles", req_cnt, cur.req_cycles);
                        pending = 1'b1;
                    end
                    req_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          we;
        logic [2:0]  f3;
        int          delay;
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b0; Addr = 32'h0;
        WriteData = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        #12;
        checkOutput("reset_readdata", ReadData, 32'h0);
        checkOutput("reset_mem_req", mem_req, 1'b0);
        checkOutput("reset_mem_we", mem_we, 1'b0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        checkOutput("reset_mem_wstrb", mem_wstrb, 4'h0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
        checkOutput("reset_bus_err", bus_err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1);
        applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0);
        applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 2);
        applyStimulus(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0);
        applyStimulus(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0);
        applyStimulus(1'b1, 3'b001, 32'h202, 32'h0000CAFE, 32'h0, 1);
        applyStimulus(1'b1, 3'b010, 32'h204, 32'h11223344, 32'h0, 0);
        applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, -1);
        applyReset();
        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'hA5A5F00D, 0);
        applyStimulus(1'b0, 3'b010, 32'h102, 32'h0, 32'h13579BDF, 0);
        applyStimulus(1'b0, 3'b001, 32'h101, 32'h0, 32'hFEDC8765, 0);
        applyStimulus(1'b0, 3'b111, 32'h108, 32'h0, 32'h0BADF00D, 0);

        for (int i = 0; i < 200; i++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            delay = (!we && $urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 3));
            applyStimulus(we, f3, $urandom, $urandom, $urandom, delay);
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
